// File: rtl/step_cfg_select.sv
// Push-button front end: sync, debounce and edge-detect up/down, then hold the step configuration.
// Optional STEP_CFG_WRAP_EN makes the value wrap at the limits instead of saturating.
module step_cfg_select #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CFG_MIN         = 1,
  parameter int unsigned CFG_MAX         = 10,
  parameter int unsigned CFG_RESET       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] step_cfg,
  output logic       cfg_changed
);

  localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] L_TERM  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] L_ONE   = CW'(1);
  localparam logic [3:0]    L_MIN   = 4'(CFG_MIN);
  localparam logic [3:0]    L_MAX   = 4'(CFG_MAX);
  localparam logic [3:0]    L_RESET = 4'(CFG_RESET);

  // Bit 0 is the up button, bit 1 the down button.
  logic [1:0]    w_raw;
  logic [1:0]    r_s1;
  logic [1:0]    r_s2;
  logic [1:0]    r_stable;
  logic [1:0]    r_stable_d;
  logic [1:0]    w_press;
  logic [CW-1:0] r_cnt [2];
  logic [3:0]    r_cfg;
  logic [3:0]    w_next;
  logic          r_changed;

  assign w_raw = {btn_down, btn_up};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1       <= w_raw;
      r_s2       <= r_s1;
      r_stable_d <= r_stable;
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == L_TERM) begin
          r_stable[i] <= r_s2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + L_ONE;
        end
      end
    end
  end

  assign w_press = r_stable & ~r_stable_d;

  always_comb begin
    w_next = r_cfg;
    if (w_press[0] && !w_press[1]) begin
      if (r_cfg < L_MAX) begin
        w_next = r_cfg + 4'd1;
      end else begin
`ifdef STEP_CFG_WRAP_EN
        w_next = L_MIN;
`else
        w_next = r_cfg;
`endif
      end
    end else if (w_press[1] && !w_press[0]) begin
      if (r_cfg > L_MIN) begin
        w_next = r_cfg - 4'd1;
      end else begin
`ifdef STEP_CFG_WRAP_EN
        w_next = L_MAX;
`else
        w_next = r_cfg;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg     <= L_RESET;
      r_changed <= 1'b0;
    end else begin
      r_cfg     <= w_next;
      r_changed <= (w_next != r_cfg);
    end
  end

  assign step_cfg    = r_cfg;
  assign cfg_changed = r_changed;

endmodule

// File: tb/tb_step_cfg_select.sv
// Directed bench for step_cfg_select with a short debounce; expectations follow STEP_CFG_WRAP_EN.
module tb_step_cfg_select;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [3:0] step_cfg;
  logic       cfg_changed;

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0;

  typedef struct {
    logic       up;
    logic       dn;
    logic [3:0] cfg;
    int         pulses;
  } vec_t;

  vec_t vecs[$];

  step_cfg_select #(
    .DEBOUNCE_CYCLES(4),
    .CFG_MIN(1),
    .CFG_MAX(10),
    .CFG_RESET(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .step_cfg(step_cfg),
    .cfg_changed(cfg_changed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cfg_changed) pulse_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic settle();
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (12) tick();
  endtask

  task automatic add(input logic up, input logic dn, input logic [3:0] cfg, input int pulses);
    vec_t v;
    v.up = up;
    v.dn = dn;
    v.cfg = cfg;
    v.pulses = pulses;
    vecs.push_back(v);
  endtask

  initial begin
    int p0;

    // Press table, starting from the reset value 1.
    for (int i = 0; i < 9; i++) add(1'b1, 1'b0, 4'(i + 2), 1);
`ifdef STEP_CFG_WRAP_EN
    add(1'b1, 1'b0, 4'd1, 1);
    add(1'b0, 1'b1, 4'd10, 1);
    add(1'b0, 1'b1, 4'd9, 1);
`else
    add(1'b1, 1'b0, 4'd10, 0);
    add(1'b1, 1'b0, 4'd10, 0);
    add(1'b1, 1'b0, 4'd10, 0);
    add(1'b0, 1'b1, 4'd9, 1);
`endif
    add(1'b1, 1'b1, 4'd9, 0);
    for (int i = 8; i >= 1; i--) add(1'b0, 1'b1, 4'(i), 1);
`ifdef STEP_CFG_WRAP_EN
    add(1'b0, 1'b1, 4'd10, 1);
`else
    add(1'b0, 1'b1, 4'd1, 0);
`endif

    // Reset value, then exact press latency with a held button.
    repeat (3) tick();
    chk("reset_cfg", int'(step_cfg), 1);
    chk("reset_changed", int'(cfg_changed), 0);
    rst    = 1'b0;
    btn_up = 1'b1;
    p0     = pulse_cnt;
    repeat (6) tick();
    chk("lat_edge6_cfg", int'(step_cfg), 1);
    tick();
    chk("lat_edge7_cfg", int'(step_cfg), 2);
    chk("lat_edge7_changed", int'(cfg_changed), 1);
    tick();
    chk("lat_edge8_changed", int'(cfg_changed), 0);
    repeat (12) tick();
    chk("held_cfg", int'(step_cfg), 2);
    chk("held_pulses", pulse_cnt - p0, 1);
    settle();

    // Bouncing press: only the final rise counts.
    p0 = pulse_cnt;
    btn_up = 1'b1; tick();
    btn_up = 1'b0; tick();
    btn_up = 1'b1; tick();
    btn_up = 1'b0; tick();
    btn_up = 1'b1;
    repeat (6) tick();
    chk("bounce_edge6_cfg", int'(step_cfg), 2);
    tick();
    chk("bounce_edge7_cfg", int'(step_cfg), 3);
    repeat (10) tick();
    chk("bounce_pulses", pulse_cnt - p0, 1);
    settle();

    // Reset two cycles into a debounce, button still held at release.
    btn_up = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_cfg", int'(step_cfg), 1);
    chk("midrst_changed", int'(cfg_changed), 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("midrst_edge6_cfg", int'(step_cfg), 1);
    tick();
    chk("midrst_edge7_cfg", int'(step_cfg), 2);
    settle();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("table_start_cfg", int'(step_cfg), 1);

    for (int i = 0; i < vecs.size(); i++) begin
      p0       = pulse_cnt;
      btn_up   = vecs[i].up;
      btn_down = vecs[i].dn;
      repeat (12) tick();
      chk($sformatf("vec%0d_cfg", i), int'(step_cfg), int'(vecs[i].cfg));
      settle();
      chk($sformatf("vec%0d_pulses", i), pulse_cnt - p0, vecs[i].pulses);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
